// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that muxes N valid/ready requesters onto one registered output channel.
// A single output register accepts a new word whenever it is empty or being drained this cycle.
module mux_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_src,
  input  logic            out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] win;
  logic          found;
  logic          canLoad;
  logic          grant;
  logic [W-1:0]  winData;

  assign canLoad   = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);
  assign grant     = |req_ready;

  // Scan requesters starting at ptr, wrapping around, and keep the first valid one.
  always_comb begin
    int            idx;
    logic [SW-1:0] sel;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = SW'(idx);
      if (!found && req_valid[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_comb begin
    winData = '0;
    for (int i = 0; i < N; i++) begin
      if (win == SW'(i)) winData = req_data[i*W +: W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && canLoad && found) req_ready[win] = 1'b1;
  end

  // A grant always (re)loads the register, which also covers drain-and-load in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (grant) begin
      state    <= FULL;
      out_data <= winData;
      out_src  <= win;
      ptr      <= (win == LAST) ? '0 : win + SW'(1);
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (N=4, W=8): directed scenarios followed by
// randomized traffic, all compared against a behavioural round-robin model.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  int          mPtr;
  logic        mValid;
  logic [7:0]  mData;
  logic [1:0]  mSrc;
  bit          mKnown = 0;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant rule: first valid requester found scanning from the priority pointer with wraparound.
  function automatic logic [3:0] expReady();
    logic [3:0] r;
    int         i;
    r = 4'b0000;
    if (!rst && (!mValid || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        i = (mPtr + k) % N;
        if (req_valid[i] && r == 4'b0000) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag);
    chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, expReady()});
    if (mKnown) begin
      chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, mValid});
      if (mValid) begin
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, mData});
        chk({tag, "_src"}, {30'd0, out_src}, {30'd0, mSrc});
      end
    end
  endtask

  task automatic updateModel(input logic [3:0] g);
    if (rst) begin
      mValid = 1'b0; mData = 8'h00; mSrc = 2'd0; mPtr = 0; mKnown = 1;
    end else if (g != 4'b0000) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          mData = req_data[i*W +: W]; mSrc = 2'(i); mPtr = (i + 1) % N; mValid = 1'b1;
        end
      end
    end else if (mValid && out_ready) begin
      mValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic ordy,
                               input logic r, input string tag);
    logic [3:0] g;
    req_valid = v; req_data = d; out_ready = ordy; rst = r;
    #2;
    checkOutput(tag);
    g = expReady();
    @(posedge clk);
    updateModel(g);
    #1;
  endtask

  initial begin
    req_valid = '0; req_data = '0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Reset and single request
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1, "rst0");
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1, "rst1");
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    applyStimulus(4'b0100, 32'h00A50000, 1'b1, 1'b0, "t1_load");
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", {24'd0, out_data}, 32'hA5);
    chk("t1_src", {30'd0, out_src}, 32'd2);
    applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0, "t1_drain");
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // Bring the pointer back to 0, then round-robin over all four
    applyStimulus(4'b1000, 32'h77000000, 1'b1, 1'b0, "t2_pre");
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 32'h13121110, 1'b1, 1'b0, "t2_rr");
      chk("t2_src", {30'd0, out_src}, 32'(c % 4));
      chk("t2_data", {24'd0, out_data}, 32'(8'h10 + c % 4));
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
    end

    // Back-pressure with word 0x11 from requester 1 held
    applyStimulus(4'b1111, 32'h13121110, 1'b1, 1'b0, "t3_pre0");
    applyStimulus(4'b1111, 32'h13121110, 1'b1, 1'b0, "t3_pre1");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 32'h13121110, 1'b0, 1'b0, "t3_stall");
      chk("t3_hold_data", {24'd0, out_data}, 32'h11);
      chk("t3_hold_src", {30'd0, out_src}, 32'd1);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    applyStimulus(4'b1111, 32'h13121110, 1'b1, 1'b0, "t3_resume");
    chk("t3_next_src", {30'd0, out_src}, 32'd2);

    // Wrap and skip from ptr=3
    applyStimulus(4'b0010, 32'h00002200, 1'b1, 1'b0, "t4_a");
    chk("t4_src1", {30'd0, out_src}, 32'd1);
    applyStimulus(4'b1001, 32'h440000BB, 1'b1, 1'b0, "t4_b");
    chk("t4_src3", {30'd0, out_src}, 32'd3);
    applyStimulus(4'b1001, 32'h440000BB, 1'b1, 1'b0, "t4_c");
    chk("t4_src0", {30'd0, out_src}, 32'd0);

    // Simultaneous drain and load, then drain alone
    applyStimulus(4'b0010, 32'h00005500, 1'b1, 1'b0, "t5_swap");
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_src", {30'd0, out_src}, 32'd1);
    applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0, "t5_drain");
    chk("t5_empty", {31'd0, out_valid}, 32'd0);

    // Reset mid-operation discards the held word and the pointer
    applyStimulus(4'b0100, 32'h00330000, 1'b1, 1'b0, "t6_load");
    chk("t6_data", {24'd0, out_data}, 32'h33);
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0, "t6_stall");
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1, "t6_rst");
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_data0", {24'd0, out_data}, 32'd0);
    applyStimulus(4'b1111, 32'h13121110, 1'b1, 1'b0, "t6_grant");
    chk("t6_src", {30'd0, out_src}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(4'($urandom), 32'($urandom), 1'(($urandom % 4) != 0),
                    1'(($urandom % 64) == 0), "rand");
    end
    req_valid = '0; out_ready = 1'b0; rst = 1'b0;
    #2;
    checkOutput("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one W-bit output channel, built from a mux tree, among N requesters.
- Uses valid/ready handshakes on every port and round-robin priority.
- The output channel is registered: one stage, with throughput of one transfer per cycle.
- Sits between the requester blocks and the single shared consumer. It is the control element that drives the mux select.

Parameters:
N, 4, number of requesters (≥1)
W, 8, data width per requester
SW, $clog2(N) (1 when N=1), width of the source index

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  N  request valid, bit i belongs to requester i
req_data  input  N*W  packed data, requester i at bits [i*W +: W]
req_ready  output  N  grant/accept, one-hot or all zero
out_valid  output  1  output register holds a valid word
out_data  output  W  registered data
out_src  output  SW  index of the requester that supplied out_data
out_ready  input  1  consumer accepts the word when out_valid && out_ready

Behaviour:
- Reset values (rst high at a posedge):
  - out_valid=0, out_data=0, out_src=0, state=EMPTY.
  - Priority pointer ptr=0, so requester 0 is highest priority.
  - req_ready=0 during the reset cycle.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) || out_ready. This is combinational.
- Arbitration (combinational):
  - When can_load=1, the winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - req_ready[winner]=1. All other bits are 0.
  - When no req_valid is set, or can_load=0, req_ready is all 0.
- Transfer on posedge, when req_valid[i] && req_ready[i]:
  - out_data <= req_data[i], out_src <= i, out_valid <= 1.
  - ptr <= (i+1) mod N. Winner N-1 wraps ptr to 0.
- Drain without reload (out_valid && out_ready, no requester granted):
  - out_valid <= 0, state -> EMPTY.
  - out_data/out_src keep their last values.
  - ptr unchanged.
- Stall (FULL && !out_ready):
  - out_valid, out_data, out_src held stable.
  - req_ready=0.
  - ptr unchanged.
- Simultaneous drain and load (FULL && out_ready && a request valid):
  - The new word replaces the old one in the same cycle.
  - out_valid stays 1. No bubble.
- Latency:
  - Accepted request appears on out_* on the cycle after the handshake edge.
  - Sustained rate is one word per clk while out_ready=1.
- Fairness: with all N requesters continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… Each requester is granted exactly once in any N consecutive grants.
- ptr changes only on a grant.
- Requesters hold req_valid and req_data stable until they see req_ready. The arbiter does not check this.
- Reset mid-operation: any word in the output register is discarded. Next cycle out_valid=0 and ptr=0.
- N=1: out_src is always 0. The block degenerates into a single-entry pipeline register with handshake.
- Combinational paths: req_valid→req_ready and out_ready→req_ready are allowed. No other path from inputs to outputs.
- out_valid never drops while out_ready=0.

Test Plan:
1. Reset, then single request: N=4, W=8. rst for 2 cycles; then req_valid=4'b0100, req_data[2]=8'hA5, out_ready=1.
   - req_ready=4'b0100 on the first cycle.
   - Next cycle out_valid=1, out_data=8'hA5, out_src=2.
   - Following cycle out_valid=0.
2. Round-robin: req_valid=4'b1111 held, each data = 8'h10+i, out_ready=1 for 8 cycles.
   - out_src sequence 0,1,2,3,0,1,2,3.
   - out_data matches source, out_valid continuously 1.
3. Back-pressure: out_valid=1 with out_data=8'h11, out_src=1; out_ready=0 for 3 cycles with req_valid=4'b1111.
   - req_ready=0 and out_* unchanged for all 3 cycles.
   - When out_ready=1, the next grant goes to requester 2.
4. Wrap and skip: ptr=3, req_valid=4'b0010.
   - Requester 1 is granted, ptr becomes 2.
   - Then req_valid=4'b1001 grants requester 3, then requester 0.
5. Simultaneous drain/load: FULL with out_src=0, out_ready=1, req_valid=4'b0010.
   - Next cycle out_valid=1, out_src=1, no empty cycle.
   - out_ready=1 with req_valid=0 gives out_valid=0 next cycle.
6. Reset mid-operation: FULL with out_data=8'h33, out_ready=0; assert rst for 1 cycle.
   - Then out_valid=0 and out_data=0.
   - The next grant with req_valid=4'b1111 goes to requester 0.
